// File: rtl/alu_seq_if.sv
// Handshake bundle for alu_seq: operand/opcode request channel and result/flag channel.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       operation;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_zero;
    logic             flag_carry;
    logic             flag_overflow;
    logic             flag_negative;
    logic             busy;

    // Source/consumer side
    modport master (
        output in_valid, A, B, operation, out_ready,
        input  in_ready, out_valid, result, flag_zero, flag_carry,
               flag_overflow, flag_negative, busy
    );

    // ALU side
    modport slave (
        input  in_valid, A, B, operation, out_ready,
        output in_ready, out_valid, result, flag_zero, flag_carry,
               flag_overflow, flag_negative, busy
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides. Single-cycle ops load the output
// register on the accept edge; MUL runs a shift-add over WIDTH cycles.
module alu_seq #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_LT = 1'b0
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {S_IDLE, S_MUL} state_t;
    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             z;
        logic             c;
        logic             v;
        logic             n;
    } res_t;

    state_t             state, state_nxt;
    logic               accept, mul_done, lt;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] mcand, acc, acc_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               out_valid_q;
    res_t               alu_r, mul_r, out_q;

    // New work only when idle and the output slot is empty or retiring this edge.
    assign bus.in_ready = !rst && (state == S_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign mul_done     = (state == S_MUL) && (cnt == CW'(WIDTH - 1));
    assign bus.busy     = (state == S_MUL);

    assign bus.out_valid     = out_valid_q;
    assign bus.result        = out_q.res;
    assign bus.flag_zero     = out_q.z;
    assign bus.flag_carry    = out_q.c;
    assign bus.flag_overflow = out_q.v;
    assign bus.flag_negative = out_q.n;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: MUL parks the FSM for WIDTH cycles, everything else stays idle
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && bus.operation == OP_MUL) state_nxt = S_MUL;
            S_MUL:   if (mul_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Single-cycle result and flags straight from the live operands
    always_comb begin
        sum   = {1'b0, bus.A} + {1'b0, bus.B};
        diff  = bus.A - bus.B;
        lt    = SIGNED_LT ? ($signed(bus.A) < $signed(bus.B)) : (bus.A < bus.B);
        alu_r = '0;
        case (bus.operation)
            3'b000: begin
                alu_r.res = sum[WIDTH-1:0];
                alu_r.c   = sum[WIDTH];
                alu_r.v   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            3'b001: begin
                alu_r.res = diff;
                alu_r.c   = bus.A < bus.B;
                alu_r.v   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
            end
            3'b010:  alu_r.res = bus.A & bus.B;
            3'b011:  alu_r.res = bus.A | bus.B;
            3'b100:  alu_r.res = bus.A ^ bus.B;
            3'b101:  alu_r.res = ~bus.A;
            3'b110:  alu_r.res = {{(WIDTH-1){1'b0}}, lt};
            default: alu_r.res = '0;   // MUL result comes from the sequencer
        endcase
        alu_r.z = (alu_r.res == '0);
        alu_r.n = alu_r.res[WIDTH-1];
    end

    // Partial product including the current multiplier bit, so the last step loads directly
    always_comb begin
        acc_nxt   = acc + (mplier[0] ? mcand : '0);
        mul_r     = '0;
        mul_r.res = acc_nxt[WIDTH-1:0];
        mul_r.c   = |acc_nxt[2*WIDTH-1:WIDTH];
        mul_r.v   = mul_r.c;
        mul_r.z   = (mul_r.res == '0);
        mul_r.n   = mul_r.res[WIDTH-1];
    end

    // Shift-add multiplier: one multiplier bit per cycle, LSB first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (accept && bus.operation == OP_MUL) begin
            mcand  <= {{WIDTH{1'b0}}, bus.A};
            mplier <= bus.B;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == S_MUL) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

    // Output slot: a load wins over retirement; held while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (accept && bus.operation != OP_MUL) begin
            out_valid_q <= 1'b1;
            out_q       <= alu_r;
        end else if (mul_done) begin
            // Slot is always empty here: MUL was only accepted with the slot free or retiring
            out_valid_q <= 1'b1;
            out_q       <= mul_r;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule
